// File: rtl/toothless_pkg.sv
// Shared opcode and FSM state types for the multi-cycle ALU and its
// iterative multiply/divide datapath.
package toothless_pkg;

   typedef enum logic [5:0] {
      ALU_ADD    = 6'd0,
      ALU_ADDU   = 6'd1,
      ALU_SUB    = 6'd2,
      ALU_SUBU   = 6'd3,
      ALU_AND    = 6'd4,
      ALU_OR     = 6'd5,
      ALU_XOR    = 6'd6,
      ALU_SLL    = 6'd7,
      ALU_SRL    = 6'd8,
      ALU_SRA    = 6'd9,
      ALU_SLT    = 6'd10,
      ALU_SLTU   = 6'd11,
      ALU_LES    = 6'd12,
      ALU_LEU    = 6'd13,
      ALU_GTS    = 6'd14,
      ALU_GTU    = 6'd15,
      ALU_GES    = 6'd16,
      ALU_GEU    = 6'd17,
      ALU_EQ     = 6'd18,
      ALU_NE     = 6'd19,
      ALU_MUL    = 6'd20,
      ALU_MULH   = 6'd21,
      ALU_MULHSU = 6'd22,
      ALU_MULHU  = 6'd23,
      ALU_DIV    = 6'd24,
      ALU_DIVU   = 6'd25,
      ALU_REM    = 6'd26,
      ALU_REMU   = 6'd27
   } alu_opcode_e;

   typedef enum logic [1:0] {
      ALU_MC_IDLE = 2'd0,
      ALU_MC_ITER = 2'd1,
      ALU_MC_DONE = 2'd2
   } alu_mc_state_e;

   function automatic logic is_muldiv(input alu_opcode_e op);
      case (op)
         ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
         ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: return 1'b1;
         default:                              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// Signed operands are handled as magnitudes; the sign is applied to the final result.
module alu_muldiv
   import toothless_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_i,
   input  logic                  start_i,
   input  alu_opcode_e           op_i,
   input  logic [DATA_WIDTH-1:0] operand_a_i,
   input  logic [DATA_WIDTH-1:0] operand_b_i,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] result_o
);

   localparam int W = DATA_WIDTH;

   logic [W-1:0]         r_hi;
   logic [W-1:0]         r_lo;
   logic [W-1:0]         r_op;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_active;
   logic                 r_div;
   logic                 r_rem;
   logic                 r_hi_sel;
   logic                 r_neg;

   logic                 w_signed_a;
   logic                 w_signed_b;
   logic                 w_div;
   logic                 w_rem;
   logic                 w_hi_sel;
   logic                 w_a_neg;
   logic                 w_b_neg;
   logic [W-1:0]         w_abs_a;
   logic [W-1:0]         w_abs_b;
   logic [W:0]           w_add;
   logic [W:0]           w_rs;
   logic [W:0]           w_diff;
   logic [W-1:0]         w_hi_nxt;
   logic [W-1:0]         w_lo_nxt;
   logic [2*W-1:0]       w_prod;
   logic [2*W-1:0]       w_prod_s;
   logic [W-1:0]         w_quo_s;
   logic [W-1:0]         w_rem_s;

   always_comb begin
      w_signed_a = 1'b0;
      w_signed_b = 1'b0;
      w_div      = 1'b0;
      w_rem      = 1'b0;
      w_hi_sel   = 1'b0;
      case (op_i)
         ALU_MULH:   begin w_signed_a = 1'b1; w_signed_b = 1'b1; w_hi_sel = 1'b1; end
         ALU_MULHSU: begin w_signed_a = 1'b1; w_hi_sel = 1'b1; end
         ALU_MULHU:  begin w_hi_sel = 1'b1; end
         ALU_DIV:    begin w_signed_a = 1'b1; w_signed_b = 1'b1; w_div = 1'b1; end
         ALU_DIVU:   begin w_div = 1'b1; end
         ALU_REM:    begin w_signed_a = 1'b1; w_signed_b = 1'b1; w_div = 1'b1; w_rem = 1'b1; end
         ALU_REMU:   begin w_div = 1'b1; w_rem = 1'b1; end
         default:    begin w_hi_sel = 1'b0; end
      endcase
   end

   assign w_a_neg = w_signed_a & operand_a_i[W-1];
   assign w_b_neg = w_signed_b & operand_b_i[W-1];
   assign w_abs_a = w_a_neg ? -operand_a_i : operand_a_i;
   assign w_abs_b = w_b_neg ? -operand_b_i : operand_b_i;

   // {r_hi, r_lo} is the product shift register (multiply) or remainder/quotient pair (divide)
   assign w_add  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : {(W+1){1'b0}});
   assign w_rs   = {r_hi, r_lo[W-1]};
   assign w_diff = w_rs - {1'b0, r_op};

   always_comb begin
      if (r_div) begin
         if (!w_diff[W]) begin
            w_hi_nxt = w_diff[W-1:0];
            w_lo_nxt = {r_lo[W-2:0], 1'b1};
         end else begin
            w_hi_nxt = w_rs[W-1:0];
            w_lo_nxt = {r_lo[W-2:0], 1'b0};
         end
      end else begin
         w_hi_nxt = w_add[W:1];
         w_lo_nxt = {w_add[0], r_lo[W-1:1]};
      end
   end

   // Result is taken from the post-step values so the last iteration lands directly in DONE
   assign w_prod   = {w_hi_nxt, w_lo_nxt};
   assign w_prod_s = r_neg ? -w_prod : w_prod;
   assign w_quo_s  = r_neg ? -w_lo_nxt : w_lo_nxt;
   assign w_rem_s  = r_neg ? -w_hi_nxt : w_hi_nxt;

   always_comb begin
      if (r_div) begin
         result_o = r_rem ? w_rem_s : w_quo_s;
      end else begin
         result_o = r_hi_sel ? w_prod_s[2*W-1:W] : w_prod_s[W-1:0];
      end
   end

   assign done_o = r_active && (r_cnt == {CNT_WIDTH{1'b0}});

   // Operand capture at start, then one iteration per cycle until the counter expires
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hi     <= {W{1'b0}};
         r_lo     <= {W{1'b0}};
         r_op     <= {W{1'b0}};
         r_cnt    <= {CNT_WIDTH{1'b0}};
         r_active <= 1'b0;
         r_div    <= 1'b0;
         r_rem    <= 1'b0;
         r_hi_sel <= 1'b0;
         r_neg    <= 1'b0;
      end else if (flush_i) begin
         r_cnt    <= {CNT_WIDTH{1'b0}};
         r_active <= 1'b0;
      end else if (start_i) begin
         r_hi     <= {W{1'b0}};
         r_lo     <= w_div ? w_abs_a : w_abs_b;
         r_op     <= w_div ? w_abs_b : w_abs_a;
         r_cnt    <= CNT_WIDTH'(DATA_WIDTH - 1);
         r_active <= 1'b1;
         r_div    <= w_div;
         r_rem    <= w_rem;
         r_hi_sel <= w_hi_sel;
         r_neg    <= w_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
      end else if (r_active) begin
         r_hi <= w_hi_nxt;
         r_lo <= w_lo_nxt;
         if (r_cnt == {CNT_WIDTH{1'b0}}) begin
            r_active <= 1'b0;
         end else begin
            r_cnt <= r_cnt - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end
      end else begin
         r_active <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops and divide corner cases complete in one cycle,
// multiply/divide iterate in alu_muldiv; the result is held until the consumer takes it.
module alu_mc
   import toothless_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  alu_opcode_e           operator_i,
   input  logic [DATA_WIDTH-1:0] operand_a_i,
   input  logic [DATA_WIDTH-1:0] operand_b_i,
   input  logic                  flush_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  busy_o
);

   localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH);
   localparam int CNT_WIDTH   = $clog2(DATA_WIDTH) + 1;

   alu_mc_state_e           r_state;
   alu_mc_state_e           w_state_nxt;
   logic [DATA_WIDTH-1:0]   r_result;

   logic [SHAMT_WIDTH-1:0]  w_shamt;
   logic [DATA_WIDTH-1:0]   w_min;
   logic                    w_lt_s;
   logic                    w_lt_u;
   logic                    w_eq;
   logic                    w_div_zero;
   logic                    w_div_ovf;
   logic                    w_bypass;
   logic                    w_go_iter;
   logic                    w_start;
   logic [DATA_WIDTH-1:0]   w_sc_result;
   logic                    w_md_done;
   logic [DATA_WIDTH-1:0]   w_md_result;

   function automatic logic [DATA_WIDTH-1:0] zext(input logic flag);
      return {{(DATA_WIDTH-1){1'b0}}, flag};
   endfunction

   assign w_shamt    = operand_b_i[SHAMT_WIDTH-1:0];
   assign w_min      = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   assign w_lt_s     = $signed(operand_a_i) < $signed(operand_b_i);
   assign w_lt_u     = operand_a_i < operand_b_i;
   assign w_eq       = operand_a_i == operand_b_i;
   assign w_div_zero = operand_b_i == {DATA_WIDTH{1'b0}};
   assign w_div_ovf  = (operand_a_i == w_min) && (operand_b_i == {DATA_WIDTH{1'b1}});

   always_comb begin
      w_sc_result = {DATA_WIDTH{1'b0}};
      w_bypass    = 1'b0;
      case (operator_i)
         ALU_ADD, ALU_ADDU: w_sc_result = operand_a_i + operand_b_i;
         ALU_SUB, ALU_SUBU: w_sc_result = operand_a_i - operand_b_i;
         ALU_AND:           w_sc_result = operand_a_i & operand_b_i;
         ALU_OR:            w_sc_result = operand_a_i | operand_b_i;
         ALU_XOR:           w_sc_result = operand_a_i ^ operand_b_i;
         ALU_SLL:           w_sc_result = operand_a_i << w_shamt;
         ALU_SRL:           w_sc_result = operand_a_i >> w_shamt;
         ALU_SRA:           w_sc_result = DATA_WIDTH'($signed(operand_a_i) >>> w_shamt);
         ALU_SLT:           w_sc_result = zext(w_lt_s);
         ALU_SLTU:          w_sc_result = zext(w_lt_u);
         ALU_LES:           w_sc_result = zext(w_lt_s | w_eq);
         ALU_LEU:           w_sc_result = zext(w_lt_u | w_eq);
         ALU_GTS:           w_sc_result = zext(~(w_lt_s | w_eq));
         ALU_GTU:           w_sc_result = zext(~(w_lt_u | w_eq));
         ALU_GES:           w_sc_result = zext(~w_lt_s);
         ALU_GEU:           w_sc_result = zext(~w_lt_u);
         ALU_EQ:            w_sc_result = zext(w_eq);
         ALU_NE:            w_sc_result = zext(~w_eq);
         // Division corner cases resolve here without iterating
         ALU_DIV: begin
            w_bypass    = w_div_zero | w_div_ovf;
            w_sc_result = w_div_zero ? {DATA_WIDTH{1'b1}} : w_min;
         end
         ALU_DIVU: begin
            w_bypass    = w_div_zero;
            w_sc_result = {DATA_WIDTH{1'b1}};
         end
         ALU_REM: begin
            w_bypass    = w_div_zero | w_div_ovf;
            w_sc_result = w_div_zero ? operand_a_i : {DATA_WIDTH{1'b0}};
         end
         ALU_REMU: begin
            w_bypass    = w_div_zero;
            w_sc_result = operand_a_i;
         end
         default:           w_sc_result = {DATA_WIDTH{1'b0}};
      endcase
   end

   assign w_go_iter = is_muldiv(operator_i) && !w_bypass;

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      if (flush_i) begin
         w_state_nxt = ALU_MC_IDLE;
      end else begin
         case (r_state)
            ALU_MC_IDLE: begin
               if (valid_i) begin
                  w_start     = w_go_iter;
                  w_state_nxt = w_go_iter ? ALU_MC_ITER : ALU_MC_DONE;
               end else begin
                  w_state_nxt = ALU_MC_IDLE;
               end
            end
            ALU_MC_ITER: w_state_nxt = w_md_done ? ALU_MC_DONE : ALU_MC_ITER;
            ALU_MC_DONE: w_state_nxt = ready_i ? ALU_MC_IDLE : ALU_MC_DONE;
            default:     w_state_nxt = ALU_MC_IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ALU_MC_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Result register: loaded on single-cycle accept or on the last iteration, cleared on flush
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_result <= {DATA_WIDTH{1'b0}};
      end else if (flush_i) begin
         r_result <= {DATA_WIDTH{1'b0}};
      end else if ((r_state == ALU_MC_IDLE) && valid_i && !w_go_iter) begin
         r_result <= w_sc_result;
      end else if ((r_state == ALU_MC_ITER) && w_md_done) begin
         r_result <= w_md_result;
      end else begin
         r_result <= r_result;
      end
   end

   alu_muldiv #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_muldiv (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush_i),
      .start_i     (w_start),
      .op_i        (operator_i),
      .operand_a_i (operand_a_i),
      .operand_b_i (operand_b_i),
      .done_o      (w_md_done),
      .result_o    (w_md_result)
   );

   assign ready_o  = (r_state == ALU_MC_IDLE);
   assign valid_o  = (r_state == ALU_MC_DONE);
   assign busy_o   = (r_state != ALU_MC_IDLE);
   assign result_o = r_result;

endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc against an arithmetic reference model,
// plus directed corner cases for divide, flush and mid-operation reset.
module tb_alu_mc;
   import toothless_pkg::*;

   localparam int DW = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        ready_i = 1'b0;
   alu_opcode_e operator_i = ALU_ADD;
   logic [DW-1:0] operand_a_i = '0;
   logic [DW-1:0] operand_b_i = '0;
   logic        ready_o;
   logic        valid_o;
   logic        busy_o;
   logic [DW-1:0] result_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_mc #(.DATA_WIDTH(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .operator_i  (operator_i),
      .operand_a_i (operand_a_i),
      .operand_b_i (operand_b_i),
      .flush_i     (flush_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .result_o    (result_o),
      .busy_o      (busy_o)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input alu_opcode_e op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, sp;
      logic [63:0] ua, ub, up;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         ALU_ADD, ALU_ADDU: return a + b;
         ALU_SUB, ALU_SUBU: return a - b;
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_SLL:  return a << (b % 32);
         ALU_SRL:  return a >> (b % 32);
         ALU_SRA:  begin sp = sa >>> (b % 32); return sp[31:0]; end
         ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
         ALU_SLTU: return (ua < ub) ? 32'd1 : 32'd0;
         ALU_LES:  return (sa <= sb) ? 32'd1 : 32'd0;
         ALU_LEU:  return (ua <= ub) ? 32'd1 : 32'd0;
         ALU_GTS:  return (sa > sb) ? 32'd1 : 32'd0;
         ALU_GTU:  return (ua > ub) ? 32'd1 : 32'd0;
         ALU_GES:  return (sa >= sb) ? 32'd1 : 32'd0;
         ALU_GEU:  return (ua >= ub) ? 32'd1 : 32'd0;
         ALU_EQ:   return (a == b) ? 32'd1 : 32'd0;
         ALU_NE:   return (a != b) ? 32'd1 : 32'd0;
         ALU_MUL:    begin sp = sa * sb; return sp[31:0]; end
         ALU_MULH:   begin sp = sa * sb; return sp[63:32]; end
         ALU_MULHSU: begin sp = sa * $signed(ub); return sp[63:32]; end
         ALU_MULHU:  begin up = ua * ub; return up[63:32]; end
         ALU_DIV: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            sp = sa / sb;
            return sp[31:0];
         end
         ALU_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         ALU_REM: begin
            if (b == 32'd0) return a;
            sp = sa % sb;
            return sp[31:0];
         end
         ALU_REMU: return (b == 32'd0) ? a : a % b;
         default:  return 32'd0;
      endcase
   endfunction

   function automatic int ref_lat(input alu_opcode_e op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU: return DW + 1;
         ALU_DIV, ALU_REM:
            return (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : DW + 1;
         ALU_DIVU, ALU_REMU: return (b == 32'd0) ? 1 : DW + 1;
         default: return 1;
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // One full request/response: accept, latency, result, hold, release with valid_i still high
   task automatic do_op(input string tag, input alu_opcode_e op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
      logic [31:0] exp;
      int exp_lat;
      int lat;
      exp     = ref_res(op, a, b);
      exp_lat = ref_lat(op, a, b);
      @(negedge clk);
      check_val({tag, "_rdy"}, ready_o, 1);
      valid_i     = 1'b1;
      operator_i  = op;
      operand_a_i = a;
      operand_b_i = b;
      ready_i     = 1'b0;
      @(negedge clk);
      operator_i  = ALU_ADD;
      operand_a_i = $urandom;
      operand_b_i = $urandom;
      lat = 1;
      while (!valid_o && lat < 3 * DW) begin
         @(negedge clk);
         lat++;
      end
      check_val({tag, "_lat"}, lat, exp_lat);
      check_val({tag, "_res"}, result_o, exp);
      check_val({tag, "_busy"}, busy_o, 1);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_val({tag, "_hold_v"}, valid_o, 1);
         check_val({tag, "_hold_r"}, result_o, exp);
      end
      ready_i = 1'b1;
      @(negedge clk);
      ready_i = 1'b0;
      check_val({tag, "_rel_v"}, valid_o, 0);
      check_val({tag, "_rel_rdy"}, ready_o, 1);
      valid_i = 1'b0;
   endtask

   initial begin
      alu_opcode_e op;
      logic seen;

      repeat (3) @(negedge clk);
      check_val("rst_ready", ready_o, 1);
      check_val("rst_valid", valid_o, 0);
      check_val("rst_busy", busy_o, 0);
      check_val("rst_result", result_o, 0);
      rst_n = 1'b1;

      do_op("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 0);
      do_op("sltu", ALU_SLTU, 32'h8000_0000, 32'd1, 0);
      do_op("slt", ALU_SLT, 32'h8000_0000, 32'd1, 0);
      do_op("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
      do_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
      do_op("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_op("divu_zero", ALU_DIVU, 32'd1234, 32'd0, 0);
      do_op("rem_zero", ALU_REM, 32'hFFFF_FFF9, 32'd0, 0);
      do_op("rem_neg", ALU_REM, 32'hFFFF_FFF9, 32'd2, 0);
      do_op("div_neg", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 0);
      do_op("mulh_neg", ALU_MULH, 32'h8000_0000, 32'h8000_0000, 0);
      do_op("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      do_op("sra", ALU_SRA, 32'h8000_0000, 32'd31, 0);
      do_op("unknown", alu_opcode_e'(6'd45), 32'd5, 32'd6, 0);

      // Flush in the 10th iteration cycle of a divide
      @(negedge clk);
      valid_i = 1'b1; operator_i = ALU_DIV; operand_a_i = 32'd1000000; operand_b_i = 32'd7;
      @(negedge clk);
      valid_i = 1'b0;
      repeat (9) @(negedge clk);
      check_val("flush_pre_busy", busy_o, 1);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      check_val("flush_ready", ready_o, 1);
      check_val("flush_valid", valid_o, 0);
      check_val("flush_busy", busy_o, 0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen = seen | valid_o;
      end
      check_val("flush_no_valid", seen, 0);
      do_op("post_flush_add", ALU_ADD, 32'd5, 32'd7, 0);

      // Reset in the middle of a multiply
      @(negedge clk);
      valid_i = 1'b1; operator_i = ALU_MUL; operand_a_i = 32'd12345; operand_b_i = 32'd678;
      @(negedge clk);
      valid_i = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_val("mrst_ready", ready_o, 1);
      check_val("mrst_valid", valid_o, 0);
      check_val("mrst_busy", busy_o, 0);
      check_val("mrst_result", result_o, 0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen = seen | valid_o;
      end
      check_val("mrst_no_valid", seen, 0);
      do_op("srl_0x21", ALU_SRL, 32'h8000_0000, 32'h21, 0);

      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 19) == 0) begin
            op = alu_opcode_e'(6'($urandom_range(28, 63)));
         end else begin
            op = alu_opcode_e'(6'($urandom_range(0, 27)));
         end
         do_op("rnd", op, pick_operand(), pick_operand(), int'($urandom_range(0, 2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width in bits (power of two, >=8).
REQ-002 SHALL have localparam SHAMT_WIDTH = log2(DATA_WIDTH): the number of significant shift-amount bits.
REQ-003 SHALL have localparam CNT_WIDTH = log2(DATA_WIDTH)+1: the iteration counter width.
REQ-004 clk  input  1  -- single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  -- reset, synchronous, active-low.
REQ-006 valid_i  input  1  -- request valid.
REQ-007 ready_o  output  1  -- unit can accept a request.
REQ-008 operator_i  input  alu_opcode_e  -- operation.
REQ-009 operand_a_i, operand_b_i  input  DATA_WIDTH each  -- operands.
REQ-010 flush_i  input  1  -- abort any operation in flight.
REQ-011 valid_o  output  1  -- result valid.
REQ-012 ready_i  input  1  -- consumer accepts the result.
REQ-013 result_o  output  DATA_WIDTH  -- registered result.
REQ-014 busy_o  output  1  -- state is not IDLE.

Function
REQ-015 FSM SHALL have three states: IDLE, ITER, DONE.
- ready_o = (state == IDLE).
- valid_o = (state == DONE).
REQ-016 Accept SHALL occur when valid_i && ready_o; operands and operator are latched at accept.
REQ-017 Single-cycle ops on accept SHALL go IDLE->DONE with result registered; valid_o is high on the next cycle (latency 1).
- Single-cycle ops: ADD/ADDU/SUB/SUBU, AND/OR/XOR, SLL/SRL/SRA, SLT/LES/GTS/GES/EQ/NE and unsigned counterparts.
REQ-018 Shifts SHALL use only operand_b[SHAMT_WIDTH-1:0]; SRA sign-fills.
REQ-019 Comparisons SHALL return zero-extended 1/0.
- *U variants compare unsigned.
- Signed variants compare two's-complement.
REQ-020 Add/sub SHALL wrap modulo 2^DATA_WIDTH with no flags.
REQ-021 MUL/MULH/MULHSU/MULHU on accept SHALL go IDLE->ITER, shift-add one bit per cycle for DATA_WIDTH cycles, then ITER->DONE.
- valid_o rises DATA_WIDTH+1 cycles after accept.
- MUL returns product[DATA_WIDTH-1:0].
- MULH* return product[2*DATA_WIDTH-1:DATA_WIDTH], signedness per opcode.
REQ-022 DIV/DIVU/REM/REMU SHALL use restoring division, one quotient bit per cycle, same latency as REQ-021.
- Signed: operands are made positive at accept, result sign is corrected at the ITER->DONE transition.
- Remainder takes the sign of the dividend.
REQ-023 Divide by zero SHALL bypass ITER (latency 1).
- Quotient = all ones.
- Remainder = operand_a.
REQ-024 Signed overflow (DIV/REM of most-negative by -1) SHALL bypass ITER (latency 1).
- Quotient = most-negative value.
- Remainder = 0.
REQ-025 In DONE, result_o and valid_o SHALL hold stable until ready_i; DONE && ready_i -> IDLE.
- No new accept occurs in that same cycle.
REQ-026 valid_i while busy SHALL be ignored (not queued); the requester must hold it.
REQ-027 flush_i SHALL force IDLE on the next edge from any state; pending result discarded, valid_o low; flush_i has priority over ready_i and valid_i.
REQ-028 Unknown operator_i SHALL complete in 1 cycle with result 0.
REQ-029 The iteration counter SHALL count DATA_WIDTH-1 down to 0; ITER->DONE when the counter is 0.

Reset
REQ-030 rst_n low at a clock edge SHALL set:
- state = IDLE, result_o = 0, counter = 0, all datapath registers = 0;
- outputs: valid_o=0, busy_o=0, ready_o=1.
REQ-031 Reset mid-ITER SHALL discard the operation with no output pulse.

Structure
REQ-032 alu_opcode_e in toothless_pkg SHALL be extended with ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU; existing encodings are unchanged.
REQ-033 The FSM state typedef alu_mc_state_e SHALL reside in toothless_pkg.
REQ-034 The iterative multiply/divide datapath SHALL be sub-module alu_muldiv.
- Has start/done and the same DATA_WIDTH parameter.
- alu_mc owns the FSM, the single-cycle ops and the output register.

Verification
REQ-035 ADD 0xFFFFFFFF+1 -> result 0x0, valid_o one cycle after accept.
REQ-036 Unsigned compare:
- SLTU a=0x80000000, b=1 -> result 0.
- SLT, same operands -> result 1.
REQ-037 MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE, valid_o 33 cycles after accept, held 5 cycles with ready_i low.
REQ-038 Divide corner cases:
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at latency 1.
- DIVU x/0 -> 0xFFFFFFFF.
- REM -7/2 -> -1.
REQ-039 flush_i in the 10th ITER cycle of DIV -> IDLE next cycle, no valid_o, next ADD correct.
REQ-040 rst_n low mid-MUL -> all outputs at reset values next edge, ready_o high; SRL with b=0x21 shifts by 1.
